// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style front end: opcodes, instruction
// field positions and default datapath widths.
package mips_pkg;

  localparam int ADDR_W_DEFAULT = 16;
  localparam int INS_W_DEFAULT  = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [31:0] OP_NOP = 32'h0000_0000;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // Sign-extend the 16-bit immediate field to a full data word.
  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational load-use and unconditional-jump detection for the
// instruction held in IF/ID against the instruction held in ID/EX.
module hazard_unit
  import mips_pkg::*;
#(
  parameter int INS_W = INS_W_DEFAULT
) (
  input  logic [INS_W-1:0] id_ins,
  input  logic             id_valid,
  input  logic             ex_valid,
  input  logic [5:0]       ex_opcode,
  input  logic [4:0]       ex_rt,
  input  logic             ex_flush,
  output logic             hz,
  output logic             jmp
);

  logic [5:0] id_opcode;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       reads_rs;
  logic       reads_rt;
  logic       lw_in_ex;
  logic       unused_low_bits;

  assign id_opcode       = id_ins[OPC_HI:OPC_LO];
  assign id_rs           = id_ins[RS_HI:RS_LO];
  assign id_rt           = id_ins[RT_HI:RT_LO];
  assign unused_low_bits = ^id_ins[IMM_HI:IMM_LO];

  // Which source registers the IF/ID instruction actually reads.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    case (id_opcode)
      OP_J: begin
        reads_rs = 1'b0;
        reads_rt = 1'b0;
      end
      OP_ADDI, OP_LW: begin
        reads_rs = 1'b1;
      end
      default: begin
        // R-type, SW and any unrecognised opcode read both sources.
        reads_rs = 1'b1;
        reads_rt = 1'b1;
      end
    endcase
  end

  assign lw_in_ex = ex_valid && (ex_opcode == OP_LW) && (ex_rt != 5'd0);

  // A flush overrides everything, so neither request is raised during one.
  assign hz  = !ex_flush && id_valid && lw_in_ex &&
               ((reads_rs && (id_rs == ex_rt)) || (reads_rt && (id_rt == ex_rt)));
  assign jmp = !ex_flush && id_valid && (id_opcode == OP_J) && !hz;

endmodule

// File: rtl/instruction_decode_stage.sv
// IF/ID and ID/EX pipeline registers with decode, load-use stalling and
// unconditional jump resolution back to the PC mux.
module instruction_decode_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int INS_W  = INS_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INS_W-1:0]  ins,
  input  logic [ADDR_W-1:0] current_address,
  input  logic              ex_flush,
  output logic [ADDR_W-1:0] jmp_loc,
  output logic              pc_mux_sel,
  output logic              stall,
  output logic              stall_pm,
  output logic              ex_valid,
  output logic [5:0]        ex_opcode,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [INS_W-1:0]  ex_imm,
  output logic [ADDR_W-1:0] ex_pc
);

  logic [INS_W-1:0]  id_ins;
  logic [ADDR_W-1:0] id_pc;
  logic              id_valid;
  logic              hz;
  logic              jmp;

  hazard_unit #(.INS_W(INS_W)) u_hazard (
    .id_ins    (id_ins),
    .id_valid  (id_valid),
    .ex_valid  (ex_valid),
    .ex_opcode (ex_opcode),
    .ex_rt     (ex_rt),
    .ex_flush  (ex_flush),
    .hz        (hz),
    .jmp       (jmp)
  );

  // IF/ID register: flush clears, hazard holds, jump inserts a bubble.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      id_ins   <= OP_NOP;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else if (ex_flush) begin
      id_ins   <= OP_NOP;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else if (hz) begin
      id_ins   <= id_ins;
      id_pc    <= id_pc;
      id_valid <= id_valid;
    end else if (jmp) begin
      id_ins   <= OP_NOP;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else begin
      id_ins   <= ins;
      id_pc    <= current_address;
      id_valid <= 1'b1;
    end
  end

  // ID/EX register: flush or hazard issue a zeroed bubble, else decode IF/ID.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || ex_flush || hz) begin
      ex_valid  <= 1'b0;
      ex_opcode <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_imm    <= '0;
      ex_pc     <= '0;
    end else begin
      ex_valid  <= id_valid;
      ex_opcode <= id_ins[OPC_HI:OPC_LO];
      ex_rs     <= id_ins[RS_HI:RS_LO];
      ex_rt     <= id_ins[RT_HI:RT_LO];
      ex_rd     <= id_ins[RD_HI:RD_LO];
      ex_imm    <= INS_W'(sign_ext16(id_ins[IMM_HI:IMM_LO]));
      ex_pc     <= id_pc;
    end
  end

  assign stall      = hz;
  assign stall_pm   = hz;
  assign pc_mux_sel = jmp;
  assign jmp_loc    = jmp ? ADDR_W'(id_ins[IMM_HI:IMM_LO]) : '0;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed self-checking bench for instruction_decode_stage.
module tb_instruction_decode_stage;

  logic        clk;
  logic        reset;
  logic [31:0] ins;
  logic [15:0] current_address;
  logic        ex_flush;
  logic [15:0] jmp_loc;
  logic        pc_mux_sel;
  logic        stall;
  logic        stall_pm;
  logic        ex_valid;
  logic [5:0]  ex_opcode;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic [31:0] ex_imm;
  logic [15:0] ex_pc;

  int checks = 0;
  int errors = 0;

  instruction_decode_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ins             (ins),
    .current_address (current_address),
    .ex_flush        (ex_flush),
    .jmp_loc         (jmp_loc),
    .pc_mux_sel      (pc_mux_sel),
    .stall           (stall),
    .stall_pm        (stall_pm),
    .ex_valid        (ex_valid),
    .ex_opcode       (ex_opcode),
    .ex_rs           (ex_rs),
    .ex_rt           (ex_rt),
    .ex_rd           (ex_rd),
    .ex_imm          (ex_imm),
    .ex_pc           (ex_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Present inputs mid-cycle and let combinational outputs settle.
  task automatic apply(input logic [31:0] i, input logic [15:0] a, input logic f);
    ins = i;
    current_address = a;
    ex_flush = f;
    #1;
  endtask

  // Advance one rising edge and sample shortly after it.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    apply(32'h2001_0005, 16'h0004, 1'b0);
    edge_step();
    edge_step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_ex_valid: got %0h expected 0", ex_valid); end
    checks++; if (ex_opcode !== 6'h0) begin errors++; $display("FAIL rst_ex_opcode: got %0h expected 0", ex_opcode); end
    checks++; if (ex_imm !== 32'h0) begin errors++; $display("FAIL rst_ex_imm: got %0h expected 0", ex_imm); end
    checks++; if ({stall, stall_pm, pc_mux_sel} !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %0b expected 000", {stall, stall_pm, pc_mux_sel}); end
    checks++; if (jmp_loc !== 16'h0) begin errors++; $display("FAIL rst_jmp_loc: got %0h expected 0", jmp_loc); end
    reset = 1'b1;
    edge_step();
    edge_step();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL rst_first_valid: got %0h expected 1", ex_valid); end
    checks++; if (ex_opcode !== 6'h08) begin errors++; $display("FAIL rst_first_opcode: got %0h expected 08", ex_opcode); end
    checks++; if (ex_rt !== 5'd1) begin errors++; $display("FAIL rst_first_rt: got %0d expected 1", ex_rt); end
    checks++; if (ex_imm !== 32'h5) begin errors++; $display("FAIL rst_first_imm: got %0h expected 5", ex_imm); end
    checks++; if (ex_pc !== 16'h0004) begin errors++; $display("FAIL rst_first_pc: got %0h expected 0004", ex_pc); end
  endtask

  task automatic test_sign_ext();
    apply(32'h2001_FFFC, 16'h0010, 1'b0);
    edge_step();
    edge_step();
    checks++; if (ex_imm !== 32'hFFFF_FFFC) begin errors++; $display("FAIL sext_imm: got %0h expected FFFFFFFC", ex_imm); end
    checks++; if (ex_pc !== 16'h0010) begin errors++; $display("FAIL sext_pc: got %0h expected 0010", ex_pc); end
  endtask

  task automatic test_jump();
    apply(32'h0000_0000, 16'h0020, 1'b0);
    edge_step();
    apply(32'h0800_0008, 16'h0024, 1'b0);
    edge_step();
    // J now in IF/ID; the sequentially fetched ADDI is on ins.
    apply(32'h2003_0007, 16'h0028, 1'b0);
    checks++; if (pc_mux_sel !== 1'b1) begin errors++; $display("FAIL jmp_sel: got %0h expected 1", pc_mux_sel); end
    checks++; if (jmp_loc !== 16'h0008) begin errors++; $display("FAIL jmp_loc: got %0h expected 0008", jmp_loc); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL jmp_no_stall: got %0h expected 0", stall); end
    edge_step();
    checks++; if ({ex_valid, ex_opcode} !== {1'b1, 6'h02}) begin errors++; $display("FAIL jmp_issue: got %0h expected 42", {ex_valid, ex_opcode}); end
    checks++; if (pc_mux_sel !== 1'b0) begin errors++; $display("FAIL jmp_sel_one_cycle: got %0h expected 0", pc_mux_sel); end
    apply(32'h2004_0001, 16'h0008, 1'b0);
    edge_step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL jmp_bubble: got %0h expected 0", ex_valid); end
    edge_step();
    checks++; if ({ex_valid, ex_rt, ex_pc} !== {1'b1, 5'd4, 16'h0008}) begin errors++; $display("FAIL jmp_target: got %0h expected %0h", {ex_valid, ex_rt, ex_pc}, {1'b1, 5'd4, 16'h0008}); end
  endtask

  task automatic test_back_to_back_jump();
    apply(32'h0800_0010, 16'h0030, 1'b0);
    edge_step();
    apply(32'h0800_0020, 16'h0034, 1'b0);
    checks++; if (jmp_loc !== 16'h0010) begin errors++; $display("FAIL b2b_loc: got %0h expected 0010", jmp_loc); end
    edge_step();
    checks++; if (pc_mux_sel !== 1'b0) begin errors++; $display("FAIL b2b_second_sel: got %0h expected 0", pc_mux_sel); end
    apply(32'h2005_0002, 16'h0010, 1'b0);
    edge_step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL b2b_bubble: got %0h expected 0", ex_valid); end
    edge_step();
    checks++; if ({ex_valid, ex_opcode, ex_pc} !== {1'b1, 6'h08, 16'h0010}) begin errors++; $display("FAIL b2b_target: got %0h expected %0h", {ex_valid, ex_opcode, ex_pc}, {1'b1, 6'h08, 16'h0010}); end
  endtask

  task automatic test_load_use();
    apply(32'h8C02_0000, 16'h0040, 1'b0);
    edge_step();
    apply(32'h0042_1820, 16'h0044, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_early_stall: got %0h expected 0", stall); end
    edge_step();
    apply(32'h2006_0003, 16'h0048, 1'b0);
    checks++; if ({stall, stall_pm} !== 2'b11) begin errors++; $display("FAIL lu_stall: got %0b expected 11", {stall, stall_pm}); end
    edge_step();
    checks++; if ({ex_valid, stall, stall_pm} !== 3'b000) begin errors++; $display("FAIL lu_bubble: got %0b expected 000", {ex_valid, stall, stall_pm}); end
    edge_step();
    checks++; if ({ex_valid, ex_opcode, ex_rs, ex_rt, ex_rd} !== {1'b1, 6'h00, 5'd2, 5'd2, 5'd3}) begin errors++; $display("FAIL lu_issue: got %0h expected %0h", {ex_valid, ex_opcode, ex_rs, ex_rt, ex_rd}, {1'b1, 6'h00, 5'd2, 5'd2, 5'd3}); end
    checks++; if (ex_pc !== 16'h0044) begin errors++; $display("FAIL lu_issue_pc: got %0h expected 0044", ex_pc); end
  endtask

  task automatic test_no_hazard_cases();
    // LW to r0 followed by an r0 reader.
    apply(32'h8C00_0000, 16'h0050, 1'b0);
    edge_step();
    apply(32'h0000_1820, 16'h0054, 1'b0);
    edge_step();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_r0_stall: got %0h expected 0", stall); end
    // LW r7 then ADDI whose rt (destination) is r7: ADDI reads rs only.
    apply(32'h8C07_0000, 16'h0058, 1'b0);
    edge_step();
    apply(32'h2007_0001, 16'h005C, 1'b0);
    edge_step();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL addi_rt_stall: got %0h expected 0", stall); end
    // LW r7 then SW storing r7: SW reads rt.
    apply(32'h8C07_0000, 16'h0060, 1'b0);
    edge_step();
    apply(32'hAC07_0000, 16'h0064, 1'b0);
    edge_step();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sw_rt_stall: got %0h expected 1", stall); end
    edge_step();
    edge_step();
    checks++; if ({ex_valid, ex_opcode} !== {1'b1, 6'h2B}) begin errors++; $display("FAIL sw_issue: got %0h expected 6b", {ex_valid, ex_opcode}); end
  endtask

  task automatic test_priorities();
    // Flush while a J sits in IF/ID.
    apply(32'h0800_0040, 16'h0070, 1'b0);
    edge_step();
    apply(32'h0000_0000, 16'h0074, 1'b1);
    checks++; if ({pc_mux_sel, jmp_loc} !== 17'h0) begin errors++; $display("FAIL flush_jmp_sel: got %0h expected 0", {pc_mux_sel, jmp_loc}); end
    edge_step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_jmp_ex: got %0h expected 0", ex_valid); end
    apply(32'h2008_0009, 16'h0074, 1'b0);
    edge_step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_ifid_cleared: got %0h expected 0", ex_valid); end
    edge_step();
    checks++; if ({ex_valid, ex_pc} !== {1'b1, 16'h0074}) begin errors++; $display("FAIL flush_resume: got %0h expected 10074", {ex_valid, ex_pc}); end
    // Flush concurrent with a load-use hazard.
    apply(32'h8C02_0000, 16'h0080, 1'b0);
    edge_step();
    apply(32'h0042_1820, 16'h0084, 1'b0);
    edge_step();
    apply(32'h0000_0000, 16'h0088, 1'b1);
    checks++; if ({stall, stall_pm} !== 2'b00) begin errors++; $display("FAIL flush_hz_stall: got %0b expected 00", {stall, stall_pm}); end
    edge_step();
    // Reset pulsed in the middle of a stall.
    apply(32'h8C02_0000, 16'h0090, 1'b0);
    edge_step();
    apply(32'h0042_1820, 16'h0094, 1'b0);
    edge_step();
    apply(32'h0000_0000, 16'h0098, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got %0h expected 1", stall); end
    reset = 1'b0;
    #1;
    checks++; if ({stall, stall_pm, pc_mux_sel, ex_valid} !== 4'b0000) begin errors++; $display("FAIL rst_mid_ctrl: got %0b expected 0000", {stall, stall_pm, pc_mux_sel, ex_valid}); end
    checks++; if ({ex_opcode, ex_rs, ex_rt, ex_rd, ex_imm, ex_pc, jmp_loc} !== 85'h0) begin errors++; $display("FAIL rst_mid_fields: got %0h expected 0", {ex_opcode, ex_rs, ex_rt, ex_rd, ex_imm, ex_pc, jmp_loc}); end
    edge_step();
    reset = 1'b1;
  endtask

  initial begin
    ins = '0;
    current_address = '0;
    ex_flush = 1'b0;
    reset = 1'b0;
    test_reset();
    test_sign_ext();
    test_jump();
    test_back_to_back_jump();
    test_load_use();
    test_no_hazard_cases();
    test_priorities();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode_stage.md
# instruction_decode_stage

Fetch-to-decode pipeline stage sitting directly downstream of the program memory / PC block. It registers the fetched `ins` and `current_address` into an IF/ID register, decodes the held instruction, and launches a decoded ID/EX bundle to execute. It closes the loop back upstream by resolving unconditional jumps (`jmp_loc`, `pc_mux_sel`) and by raising `stall` / `stall_pm` on load-use hazards.

## Interface
- `ADDR_W`, 16: PC / jump-target width.
- `INS_W`, 32: instruction width.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ins`  in  32  instruction from program memory.
- `current_address`  in  16  PC of `ins`.
- `ex_flush`  in  1  branch taken in execute; squash IF/ID and ID/EX.
- `jmp_loc`  out  16  jump target to PC mux.
- `pc_mux_sel`  out  1  1 = PC loads `jmp_loc`.
- `stall`  out  1  freeze PC.
- `stall_pm`  out  1  freeze program-memory output.
- `ex_valid`  out  1  ID/EX holds a real instruction.
- `ex_opcode`  out  6  `ins[31:26]`.
- `ex_rs`, `ex_rt`, `ex_rd`  out  5 each  `ins[25:21]`, `[20:16]`, `[15:11]`.
- `ex_imm`  out  32  `ins[15:0]` sign-extended.
- `ex_pc`  out  16  PC of the ID/EX instruction.

## Operation
- Opcodes: R-type 6'h00, ADDI 6'h08, LW 6'h23, SW 6'h2B, J 6'h02. Any other opcode decodes as R-type. `32'h0` is NOP.
- Register reads:
  - R-type and SW read `rs` and `rt`.
  - ADDI and LW read `rs` only.
  - J reads nothing.
- IF/ID register fields: `id_ins`, `id_pc`, `id_valid`.
- Load-use hazard, `hz`: asserted when all of the following hold:
  - `ex_valid` = 1 and `ex_opcode` = LW;
  - `ex_rt` != 0;
  - `ex_rt` equals a register read by `id_ins`;
  - `id_valid` = 1.
- Jump, `jmp`: asserted when `id_valid` = 1, `id_ins[31:26]` = J, and `hz` = 0 (by construction `hz` is never set for a J).
- Per-edge update priority, highest first:
  1. `ex_flush`: IF/ID gets `id_valid`=0, `id_ins`=0. ID/EX gets `ex_valid`=0 and all fields 0.
  2. `hz`: IF/ID holds. ID/EX gets a bubble (`ex_valid`=0, fields 0).
  3. `jmp`: ID/EX captures the J with `ex_valid`=1. IF/ID gets a bubble, which squashes the sequential fetch.
  4. Otherwise: IF/ID captures `ins` / `current_address` with `id_valid`=1. ID/EX captures the decoded `id_*`, with `ex_valid` = `id_valid`.
- Combinational outputs, all gated to 0 when `ex_flush` = 1:
  - `stall` = `stall_pm` = `hz`.
  - `pc_mux_sel` = `jmp`.
  - `jmp_loc` = `id_ins[15:0]` when `jmp` = 1, else 0.

## Timing
- Reset (async, `reset`=0): every register clears to 0, `id_valid`=0, `ex_valid`=0. All outputs read 0 while reset is low.
- First edge after `reset` rises captures `ins` into IF/ID.
- Latency: an instruction presented at edge N appears on `ex_*` after edge N+1.
- Jump: `pc_mux_sel` is high for exactly one cycle, during the cycle the J sits in IF/ID. The target instruction enters IF/ID two edges after the J entered. Exactly one bubble is inserted.
- Load-use: `stall` / `stall_pm` are high for exactly one cycle. The dependent instruction reaches ID/EX one cycle late, behind one bubble.
- Reset asserted mid-stall or mid-jump: the stall and jump are abandoned immediately and all outputs go to 0.
- `ex_flush` concurrent with `hz` or `jmp`: the flush wins, and no stall or jump is requested that cycle.
- Back-to-back J instructions: the second J is squashed as the bubble and never issues.

## Structure
- Shared package `mips_pkg`:
  - opcode localparams;
  - the `OP_NOP` instruction constant;
  - field bit positions;
  - `ADDR_W` / `INS_W` defaults.
- Sub-module `hazard_unit`: purely combinational. Inputs are `id_ins`, `id_valid`, `ex_valid`, `ex_opcode`, `ex_rt`, `ex_flush`. Outputs are `hz`, `jmp`.
- Registers and priority muxing live in `instruction_decode_stage`.

## Test plan
- **Reset:** hold `reset`=0, drive `ins`=32'h2001_0005 → all outputs 0. Release, then 2 edges later → `ex_valid`=1, `ex_opcode`=6'h08, `ex_rt`=1, `ex_imm`=32'h5.
- **Sign extension:** `ins`=32'h2001_FFFC → `ex_imm`=32'hFFFF_FFFC.
- **Jump:** stream NOP, J (32'h0800_0008), ADDI.
  - Expected: during the J's IF/ID cycle, `pc_mux_sel`=1 and `jmp_loc`=16'h0008.
  - The following ADDI never reaches `ex_valid`=1; one bubble is issued.
- **Load-use:** LW r2 (32'h8C02_0000) then R-type reading r2 (32'h0042_1820).
  - Expected: `stall`=`stall_pm`=1 for one cycle, one bubble, then the R-type issues with `ex_rs`=2.
- **LW to r0:** `ex_rt`=0 followed by a reader of r0 → no stall.
- **Priorities:**
  - Assert `ex_flush` in the same cycle as a J in IF/ID → `pc_mux_sel`=0, next `ex_valid`=0.
  - Pulse `reset` low mid-stall → all outputs 0 asynchronously.
